// File: rtl/accum_pkg.sv
// rtl/accum_pkg.sv - shared state encoding and default widths for accum_sequencer
package accum_pkg;

    localparam int DEFAULT_DATA_WIDTH = 4;
    localparam int STATE_WIDTH        = 2;

    typedef enum logic [STATE_WIDTH-1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/accum_sequencer.sv
// rtl/accum_sequencer.sv - multi-operand accumulator controller around an external adder
//
// Optional feature macro: ACCUM_OVERFLOW_EN (sticky unsigned-wrap flag on overflow_out).
//
// Ports:
//   clk_in            rising-edge clock
//   rst_n_in          asynchronous active-low reset
//   start_in          begin a new accumulation (honoured in IDLE only)
//   operand_in        operand data
//   operand_valid_in  operand_in is valid
//   operand_ready_out operand accepted this cycle (ACCUM only)
//   add_a_out         to adder: registered running sum
//   add_b_out         to adder: operand_in pass-through
//   add_sum_in        from adder: add_a_out + add_b_out
//   result_out        final sum (DONE only, else 0)
//   result_valid_out  result_out is valid
//   result_ready_in   consumer takes the result
//   busy_out          state is not IDLE
//   overflow_out      sticky wrap flag shown in DONE (0 when feature disabled)
module accum_sequencer
    import accum_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int NUM_OPERANDS = 4,
    parameter int CNT_WIDTH    = 3
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  start_in,
    input  logic [DATA_WIDTH-1:0] operand_in,
    input  logic                  operand_valid_in,
    output logic                  operand_ready_out,
    output logic [DATA_WIDTH-1:0] add_a_out,
    output logic [DATA_WIDTH-1:0] add_b_out,
    input  logic [DATA_WIDTH-1:0] add_sum_in,
    output logic [DATA_WIDTH-1:0] result_out,
    output logic                  result_valid_out,
    input  logic                  result_ready_in,
    output logic                  busy_out,
    output logic                  overflow_out
);

    // Counter value at which the incoming transfer is the final operand.
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(NUM_OPERANDS - 1);

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] sum, sum_nxt;
    logic [CNT_WIDTH-1:0]  cnt, cnt_nxt;
    logic                  xfer;

    assign xfer = (state == ST_ACCUM) && operand_valid_in;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= ST_IDLE;
            sum   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            sum   <= sum_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        sum_nxt           = sum;
        cnt_nxt           = cnt;
        operand_ready_out = 1'b0;
        result_valid_out  = 1'b0;
        result_out        = '0;
        busy_out          = 1'b1;
        case (state)
            ST_IDLE: begin
                busy_out = 1'b0;
                if (start_in) begin
                    sum_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                operand_ready_out = 1'b1;
                if (xfer) begin
                    sum_nxt = add_sum_in;
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                result_valid_out = 1'b1;
                result_out       = sum;
                if (result_ready_in) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign add_a_out = sum;
    // Gated by reset so every output reads 0 while reset is held.
    assign add_b_out = rst_n_in ? operand_in : '0;

`ifdef ACCUM_OVERFLOW_EN
    logic ovf, ovf_nxt;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ovf <= 1'b0;
        end else begin
            ovf <= ovf_nxt;
        end
    end

    always_comb begin
        ovf_nxt = ovf;
        if ((state == ST_IDLE) && start_in) begin
            ovf_nxt = 1'b0;
        end else if (xfer && (add_sum_in < sum)) begin
            // A sum smaller than the running sum means the adder wrapped.
            ovf_nxt = 1'b1;
        end
    end

    assign overflow_out = (state == ST_DONE) && ovf;
`else
    assign overflow_out = 1'b0;
`endif

endmodule

// File: tb/tb_accum_sequencer.sv
// tb/tb_accum_sequencer.sv - self-checking bench for accum_sequencer
module tb_accum_sequencer;

    localparam int DW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;

    // instance 0: NUM_OPERANDS = 4
    logic          start, valid, rready;
    logic [DW-1:0] operand;
    logic          oready, rvalid, busy, ovf;
    logic [DW-1:0] add_a, add_b, add_sum, result;

    // instance 1: NUM_OPERANDS = 1
    logic          start1, valid1, rready1;
    logic [DW-1:0] operand1;
    logic          oready1, rvalid1, busy1, ovf1;
    logic [DW-1:0] add_a1, add_b1, add_sum1, result1;

    // stand-in for the team adder
    assign add_sum  = add_a + add_b;
    assign add_sum1 = add_a1 + add_b1;

    accum_sequencer #(.DATA_WIDTH(DW), .NUM_OPERANDS(4), .CNT_WIDTH(3)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start),
        .operand_in(operand), .operand_valid_in(valid), .operand_ready_out(oready),
        .add_a_out(add_a), .add_b_out(add_b), .add_sum_in(add_sum),
        .result_out(result), .result_valid_out(rvalid), .result_ready_in(rready),
        .busy_out(busy), .overflow_out(ovf)
    );

    accum_sequencer #(.DATA_WIDTH(DW), .NUM_OPERANDS(1), .CNT_WIDTH(1)) dut1 (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start1),
        .operand_in(operand1), .operand_valid_in(valid1), .operand_ready_out(oready1),
        .add_a_out(add_a1), .add_b_out(add_b1), .add_sum_in(add_sum1),
        .result_out(result1), .result_valid_out(rvalid1), .result_ready_in(rready1),
        .busy_out(busy1), .overflow_out(ovf1)
    );

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet0(input string tag);
        chk({tag, ".oready"}, 32'(oready), 0);
        chk({tag, ".rvalid"}, 32'(rvalid), 0);
        chk({tag, ".result"}, 32'(result), 0);
        chk({tag, ".busy"},   32'(busy),   0);
        chk({tag, ".ovf"},    32'(ovf),    0);
        chk({tag, ".add_a"},  32'(add_a),  0);
        chk({tag, ".add_b"},  32'(add_b),  0);
    endtask

    function automatic bit ovf_en();
`ifdef ACCUM_OVERFLOW_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Full transaction on instance 0; expectations come from integer arithmetic.
    task automatic run_txn(input string tag, input logic [DW-1:0] ops[$],
                           input int gap, input int rdly, input bit poke_start);
        int unsigned acc;
        bit          wrap;
        acc  = 0;
        wrap = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, ".busy_accum"},  32'(busy), 1);
        chk({tag, ".ready_accum"}, 32'(oready), 1);
        foreach (ops[i]) begin
            repeat (gap) begin
                valid   = 1'b0;
                operand = DW'($urandom);
                tick();
                chk({tag, ".gap_ready"},  32'(oready), 1);
                chk({tag, ".gap_rvalid"}, 32'(rvalid), 0);
            end
            valid   = 1'b1;
            operand = ops[i];
            #1;
            chk({tag, ".add_a"}, 32'(add_a), acc % 16);
            chk({tag, ".add_b"}, 32'(add_b), 32'(ops[i]));
            if ((acc % 16) + ops[i] >= 16) wrap = 1'b1;
            acc += ops[i];
            tick();
            valid = 1'b0;
        end
        // one cycle after the last accept
        chk({tag, ".rvalid"}, 32'(rvalid), 1);
        chk({tag, ".result"}, 32'(result), acc % 16);
        chk({tag, ".ovf"},    32'(ovf),    32'(wrap & ovf_en()));
        chk({tag, ".oready_done"}, 32'(oready), 0);
        repeat (rdly) begin
            rready = 1'b0;
            start  = poke_start;
            tick();
            start  = 1'b0;
            chk({tag, ".hold_rvalid"}, 32'(rvalid), 1);
            chk({tag, ".hold_result"}, 32'(result), acc % 16);
            chk({tag, ".hold_oready"}, 32'(oready), 0);
        end
        rready = 1'b1;
        start  = poke_start;
        tick();
        rready = 1'b0;
        start  = 1'b0;
        chk({tag, ".post_rvalid"}, 32'(rvalid), 0);
        chk({tag, ".post_busy"},   32'(busy),   0);
        chk({tag, ".post_result"}, 32'(result), 0);
        tick();
        chk({tag, ".idle_busy"}, 32'(busy), 0);
    endtask

    initial begin
        logic [DW-1:0] q[$];

        rst_n = 1'b0;
        start = 0; valid = 0; rready = 0; operand = 0;
        start1 = 0; valid1 = 0; rready1 = 0; operand1 = 0;

        // 1. reset with random inputs
        repeat (3) begin
            start   = 1'($urandom);
            valid   = 1'($urandom);
            rready  = 1'($urandom);
            operand = DW'($urandom);
            #1;
            chk_quiet0("reset");
            chk("reset.busy1",  32'(busy1),  0);
            chk("reset.rvalid1", 32'(rvalid1), 0);
            tick();
        end
        start = 0; valid = 0; rready = 0; operand = 0;
        #3 rst_n = 1'b1;
        tick();
        valid = 1'b1;
        tick();
        chk_quiet0("post_reset");
        valid = 1'b0;

        // 2. basic sum
        q = '{4'd1, 4'd2, 4'd3, 4'd4};
        run_txn("basic", q, 0, 0, 1'b0);

        // 3. wrap
        q = '{4'd15, 4'd1, 4'd0, 4'd0};
        run_txn("wrap", q, 0, 0, 1'b0);

        // 4. backpressure with start pokes in DONE
        q = '{4'd2, 4'd2, 4'd2, 4'd2};
        run_txn("bp", q, 2, 3, 1'b1);

        // 5. mid-operation reset
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) begin
            valid = 1'b1;
            operand = 4'd3;
            tick();
        end
        valid   = 1'b1;
        operand = DW'($urandom_range(1, 15));
        #2 rst_n = 1'b0;
        #1;
        chk_quiet0("midrst");
        tick();
        #3 rst_n = 1'b1;
        valid   = 1'b0;
        operand = 0;
        tick();
        chk_quiet0("midrst_idle");
        q = '{4'd5, 4'd5, 4'd5, 4'd5};
        run_txn("after_rst", q, 0, 0, 1'b0);

        // 6. single-operand instance
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("n1.busy",   32'(busy1),   1);
        chk("n1.oready", 32'(oready1), 1);
        valid1   = 1'b1;
        operand1 = 4'd7;
        tick();
        valid1 = 1'b0;
        chk("n1.rvalid", 32'(rvalid1), 1);
        chk("n1.result", 32'(result1), 7);
        chk("n1.ovf",    32'(ovf1),    0);
        rready1 = 1'b0;
        tick();
        chk("n1.hold_busy",   32'(busy1),   1);
        chk("n1.hold_result", 32'(result1), 7);
        rready1 = 1'b1;
        tick();
        rready1 = 1'b0;
        chk("n1.post_busy",   32'(busy1),   0);
        chk("n1.post_rvalid", 32'(rvalid1), 0);

        // randomized transactions
        for (int t = 0; t < 8; t++) begin
            q.delete();
            for (int k = 0; k < 4; k++) q.push_back(DW'($urandom_range(0, 15)));
            run_txn("rand", q, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                    1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
